// File: rtl/top_stage.sv
// top_stage: in-place 512-point mixed-radix NTT over q = 12289.
// One radix-2 DIF stage (stride 256), then four radix-4 DIF stages (strides 64, 16, 4, 1).
// Data lives in four banks. The element-to-bank mapping keeps every issue cycle conflict-free.
// Datapath: issue -> read (p0) -> butterfly part 1 (p1) -> butterfly part 2 (p2) -> twiddle multiply (p3) -> write-back.

module ntt_bank #(
  parameter int DW = 14,
  parameter int AW = 7
) (
  input  logic          clk,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata
);
  reg [DW-1:0] bank [0:(1<<AW)-1];

  // One registered read and one synchronous write per cycle
  always_ff @(posedge clk) begin
    rdata <= bank[raddr];
    if (we) bank[waddr] <= wdata;
  end
endmodule

module top_stage #(
  parameter int Q     = 12289,
  parameter int DW    = 14,
  parameter int AW    = 7,
  parameter int OMEGA = 2401,
  parameter int PIPE  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] conf,
  output logic [1:0] done_flag
);
  localparam logic [DW:0] QX = (DW+1)'(Q);

  // OMEGA^e mod Q by square-and-multiply; used only at elaboration
  function automatic int unsigned pow_mod(input int unsigned e);
    int unsigned r;
    int unsigned b;
    r = 1;
    b = OMEGA;
    for (int i = 0; i < 9; i++) begin
      if (e[i]) r = (r * b) % Q;
      b = (b * b) % Q;
    end
    return r;
  endfunction

  // Bank holding element e: digit sum of the low four radix-4 digits plus 2*e[8], mod 4
  function automatic logic [1:0] bank_of(input logic [8:0] e);
    return e[1:0] + e[3:2] + e[5:4] + e[7:6] + {e[8], 1'b0};
  endfunction

  function automatic logic [DW-1:0] mod_add(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [DW:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= QX) s = s - QX;
    return s[DW-1:0];
  endfunction

  function automatic logic [DW-1:0] mod_sub(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [DW:0] d;
    d = {1'b0, a} - {1'b0, b};
    if (a < b) d = d + QX;
    return d[DW-1:0];
  endfunction

  function automatic logic [DW-1:0] mod_mul(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [2*DW-1:0] p;
    p = {{DW{1'b0}}, a} * {{DW{1'b0}}, b};
    p = p % (2*DW)'(Q);
    return p[DW-1:0];
  endfunction

  localparam logic [DW-1:0] J_VAL = DW'(pow_mod(128));

  typedef enum logic [2:0] {IDLE, R2_RUN, R2_DRAIN, R4_RUN, R4_DRAIN} state_t;

  state_t        state;
  logic [6:0]    cnt;
  logic [1:0]    stage;
  logic [3:0]    conf_prev;

  logic [8:0]    g9, lo_mask, base, jidx, tj;
  logic [3:0]    dsh, tsh;
  logic [8:0]    elem [4];
  logic [8:0]    expo [4];

  logic [AW-1:0] raddr [4];
  logic [DW-1:0] rdata [4];
  logic          we    [4];
  logic [AW-1:0] waddr [4];
  logic [DW-1:0] wdata [4];
  logic [DW-1:0] xin   [4];
  logic [DW-1:0] tw_rom [512];

  logic          vld_p0, vld_p1, vld_p2, vld_p3;
  logic          r4_p0, r4_p1;
  logic [1:0]    bk_p0 [4], bk_p1 [4], bk_p2 [4], bk_p3 [4];
  logic [AW-1:0] addr_p0 [4], addr_p1 [4], addr_p2 [4], addr_p3 [4];
  logic [8:0]    exp_p0 [4];
  logic [DW-1:0] a_p1, b_p1, c_p1, d_p1;
  logic [DW-1:0] w_p1 [4], w_p2 [4], u_p2 [4], y_p3 [4];

  for (genvar k = 0; k < 512; k++) begin : g_tw
    localparam logic [DW-1:0] TWV = DW'(pow_mod(k));
    assign tw_rom[k] = TWV;
  end

  ntt_bank #(.DW(DW), .AW(AW)) bank_0 (.clk(clk), .raddr(raddr[0]), .rdata(rdata[0]),
    .we(we[0]), .waddr(waddr[0]), .wdata(wdata[0]));
  ntt_bank #(.DW(DW), .AW(AW)) bank_1 (.clk(clk), .raddr(raddr[1]), .rdata(rdata[1]),
    .we(we[1]), .waddr(waddr[1]), .wdata(wdata[1]));
  ntt_bank #(.DW(DW), .AW(AW)) bank_2 (.clk(clk), .raddr(raddr[2]), .rdata(rdata[2]),
    .we(we[2]), .waddr(waddr[2]), .wdata(wdata[2]));
  ntt_bank #(.DW(DW), .AW(AW)) bank_3 (.clk(clk), .raddr(raddr[3]), .rdata(rdata[3]),
    .we(we[3]), .waddr(waddr[3]), .wdata(wdata[3]));

  // Control FSM: edge-qualified commands accepted only in IDLE; runs always complete unless reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      stage     <= '0;
      done_flag <= '0;
      conf_prev <= '0;
    end else begin
      conf_prev <= conf;
      case (state)
        IDLE: begin
          if (conf == 4'd1 && conf_prev != 4'd1) begin
            state        <= R2_RUN;
            cnt          <= '0;
            done_flag[0] <= 1'b0;
          end else if (conf == 4'd2 && conf_prev != 4'd2) begin
            state        <= R4_RUN;
            cnt          <= '0;
            stage        <= '0;
            done_flag[1] <= 1'b0;
          end
        end
        R2_RUN: begin
          cnt <= cnt + 7'd1;
          if (cnt == 7'd127) state <= R2_DRAIN;
        end
        R2_DRAIN: begin
          if (cnt == 7'(PIPE-1)) begin
            cnt          <= '0;
            state        <= IDLE;
            done_flag[0] <= 1'b1;
          end else begin
            cnt <= cnt + 7'd1;
          end
        end
        R4_RUN: begin
          cnt <= cnt + 7'd1;
          if (cnt == 7'd127) state <= R4_DRAIN;
        end
        R4_DRAIN: begin
          if (cnt == 7'(PIPE-1)) begin
            cnt <= '0;
            if (stage == 2'd3) begin
              state        <= IDLE;
              done_flag[1] <= 1'b1;
            end else begin
              stage <= stage + 2'd1;
              state <= R4_RUN;
            end
          end else begin
            cnt <= cnt + 7'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Issue: element indices and twiddle exponents for the current group
  always_comb begin
    g9      = {2'b00, cnt};
    dsh     = 4'({~stage, 1'b0});
    tsh     = 4'd7 - dsh;
    lo_mask = (9'd1 << dsh) - 9'd1;
    base    = ((g9 >> dsh) << (dsh + 4'd2)) | (g9 & lo_mask);
    jidx    = g9 & lo_mask;
    tj      = jidx << tsh;
    if (state == R4_RUN) begin
      for (int p = 0; p < 4; p++) elem[p] = base + (9'(p) << dsh);
      expo[0] = '0;
      expo[1] = tj;
      expo[2] = tj << 1;
      expo[3] = tj + (tj << 1);
    end else begin
      elem[0] = {1'b0, cnt, 1'b0};
      elem[1] = {1'b0, cnt, 1'b1};
      elem[2] = {1'b1, cnt, 1'b0};
      elem[3] = {1'b1, cnt, 1'b1};
      expo[0] = '0;
      expo[1] = '0;
      expo[2] = {1'b0, cnt, 1'b0};
      expo[3] = {1'b0, cnt, 1'b1};
    end
  end

  // Read address steering: each element lands in a distinct bank
  always_comb begin
    for (int b = 0; b < 4; b++) raddr[b] = '0;
    for (int p = 0; p < 4; p++) raddr[bank_of(elem[p])] = elem[p][8:2];
  end

  // Valid chain; the only pipeline state cleared by reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
      vld_p3 <= 1'b0;
    end else begin
      vld_p0 <= (state == R2_RUN) || (state == R4_RUN);
      vld_p1 <= vld_p0;
      vld_p2 <= vld_p1;
      vld_p3 <= vld_p2;
    end
  end

  // p0 boundary: capture element routing alongside the bank read
  always_ff @(posedge clk) begin
    r4_p0 <= (state == R4_RUN);
    for (int p = 0; p < 4; p++) begin
      bk_p0[p]   <= bank_of(elem[p]);
      addr_p0[p] <= elem[p][8:2];
      exp_p0[p]  <= expo[p];
    end
  end

  // Undo the bank permutation so xin[k] is element k of the group
  always_comb begin
    for (int k = 0; k < 4; k++) xin[k] = rdata[bk_p0[k]];
  end

  // p1 boundary: first butterfly layer; radix-2 reuses a/b and c/d as two independent pairs
  always_ff @(posedge clk) begin
    a_p1  <= mod_add(xin[0], xin[2]);
    b_p1  <= mod_sub(xin[0], xin[2]);
    c_p1  <= mod_add(xin[1], xin[3]);
    d_p1  <= r4_p0 ? mod_mul(J_VAL, mod_sub(xin[1], xin[3])) : mod_sub(xin[1], xin[3]);
    r4_p1 <= r4_p0;
    for (int k = 0; k < 4; k++) begin
      w_p1[k]    <= tw_rom[exp_p0[k]];
      bk_p1[k]   <= bk_p0[k];
      addr_p1[k] <= addr_p0[k];
    end
  end

  // p2 boundary: second butterfly layer (radix-4) or pass-through of the radix-2 sums/differences
  always_ff @(posedge clk) begin
    u_p2[0] <= r4_p1 ? mod_add(a_p1, c_p1) : a_p1;
    u_p2[1] <= r4_p1 ? mod_add(b_p1, d_p1) : c_p1;
    u_p2[2] <= r4_p1 ? mod_sub(a_p1, c_p1) : b_p1;
    u_p2[3] <= r4_p1 ? mod_sub(b_p1, d_p1) : d_p1;
    for (int k = 0; k < 4; k++) begin
      w_p2[k]    <= w_p1[k];
      bk_p2[k]   <= bk_p1[k];
      addr_p2[k] <= addr_p1[k];
    end
  end

  // p3 boundary: twiddle multiply (exponent 0 gives a multiply by one)
  always_ff @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      y_p3[k]    <= mod_mul(u_p2[k], w_p2[k]);
      bk_p3[k]   <= bk_p2[k];
      addr_p3[k] <= addr_p2[k];
    end
  end

  // Write-back steering: results return to the words they were read from
  always_comb begin
    for (int b = 0; b < 4; b++) begin
      we[b]    = 1'b0;
      waddr[b] = '0;
      wdata[b] = '0;
    end
    for (int b = 0; b < 4; b++) begin
      for (int k = 0; k < 4; k++) begin
        if (bk_p3[k] == 2'(b)) begin
          we[b]    = vld_p3;
          waddr[b] = addr_p3[k];
          wdata[b] = y_p3[k];
        end
      end
    end
  end
endmodule

// File: tb/tb_top_stage.sv
// tb_top_stage: table of load patterns and phase sequences, with expected memory images
// queued from a software NTT model and compared when the engine reports completion.

module tb_top_stage;
  localparam int Q     = 12289;
  localparam int OMEGA = 2401;
  localparam int PIPE  = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] conf = 4'd0;
  logic [1:0] done_flag;

  int n_tests = 0;
  int n_fail  = 0;
  int x_m [512];
  int tw  [512];
  int exp_q [$];

  typedef struct {
    int pat;
    int phases;
    int mid;
    int i0;
    int v0;
    int i1;
    int v1;
    int done;
  } vec_t;
  vec_t vecs [5];

  top_stage dut (.clk(clk), .rst(rst), .conf(conf), .done_flag(done_flag));

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d", n_tests);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  function automatic int madd(input int a, input int b);
    return (a + b) % Q;
  endfunction
  function automatic int msub(input int a, input int b);
    return (a - b + Q) % Q;
  endfunction
  function automatic int mmul(input int a, input int b);
    return int'((longint'(a) * longint'(b)) % longint'(Q));
  endfunction

  function automatic int bank_of(input int i);
    return ((i & 3) + ((i >> 2) & 3) + ((i >> 4) & 3) + ((i >> 6) & 3) + 2 * ((i >> 8) & 1)) % 4;
  endfunction

  task automatic poke(input int i, input int v);
    case (bank_of(i))
      0: dut.bank_0.bank[i >> 2] = 14'(v);
      1: dut.bank_1.bank[i >> 2] = 14'(v);
      2: dut.bank_2.bank[i >> 2] = 14'(v);
      default: dut.bank_3.bank[i >> 2] = 14'(v);
    endcase
  endtask

  function automatic int peek(input int i);
    case (bank_of(i))
      0: return int'(dut.bank_0.bank[i >> 2]);
      1: return int'(dut.bank_1.bank[i >> 2]);
      2: return int'(dut.bank_2.bank[i >> 2]);
      default: return int'(dut.bank_3.bank[i >> 2]);
    endcase
  endfunction

  function automatic int writes_active();
    return int'(dut.bank_0.we) + int'(dut.bank_1.we) + int'(dut.bank_2.we) + int'(dut.bank_3.we);
  endfunction

  task automatic load(input int pat);
    int v;
    for (int i = 0; i < 512; i++) begin
      case (pat)
        0: v = (i == 0) ? 5 : ((i == 256) ? 3 : 0);
        1: v = (i == 0) ? 1 : 0;
        2: v = 1;
        3: v = int'($urandom_range(0, Q - 1));
        default: v = (i * 37 + 11) % Q;
      endcase
      x_m[i] = v;
      poke(i, v);
    end
  endtask

  task automatic model_r2();
    int a, b;
    for (int j = 0; j < 256; j++) begin
      a = x_m[j];
      b = x_m[j + 256];
      x_m[j]       = madd(a, b);
      x_m[j + 256] = mmul(msub(a, b), tw[j]);
    end
  endtask

  task automatic model_r4();
    int t, bs, x0, x1, x2, x3, jv;
    jv = tw[128];
    for (int s = 64; s >= 1; s = s / 4) begin
      t = 512 / (4 * s);
      for (int blk = 0; blk < 512; blk += 4 * s) begin
        for (int j = 0; j < s; j++) begin
          bs = blk + j;
          x0 = x_m[bs]; x1 = x_m[bs + s]; x2 = x_m[bs + 2 * s]; x3 = x_m[bs + 3 * s];
          x_m[bs]         = madd(madd(x0, x1), madd(x2, x3));
          x_m[bs + s]     = mmul(msub(madd(x0, mmul(jv, x1)), madd(x2, mmul(jv, x3))), tw[(t * j) % 512]);
          x_m[bs + 2 * s] = mmul(msub(madd(x0, x2), madd(x1, x3)), tw[(2 * t * j) % 512]);
          x_m[bs + 3 * s] = mmul(msub(madd(x0, mmul(jv, x3)), madd(x2, mmul(jv, x1))), tw[(3 * t * j) % 512]);
        end
      end
    end
  endtask

  task automatic push_expected();
    for (int i = 0; i < 512; i++) exp_q.push_back(x_m[i]);
  endtask

  task automatic compare_mem(input string name);
    int bad, first, fa, fe, e, a;
    bad = 0; first = -1; fa = 0; fe = 0;
    for (int i = 0; i < 512; i++) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
      a = peek(i);
      if (a != e) begin
        bad++;
        if (first < 0) begin first = i; fa = a; fe = e; end
      end
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL mem_%s: %0d words differ, first x[%0d] got %0d expected %0d", name, bad, first, fa, fe);
    end
  endtask

  // Start a phase, optionally change conf mid-run, and wait (bounded) for its done bit.
  task automatic run_phase(input int ph, input int mid_en, output int elapsed);
    int  cyc;
    bit  seen;
    @(negedge clk);
    conf = 4'(ph);
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 2000) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (cyc == 1) check($sformatf("done%0d_cleared_at_start", ph - 1), int'(done_flag[ph - 1]), 0);
      if (mid_en != 0) begin
        if (ph == 1 && cyc == 60)  conf = 4'd3;
        if (ph == 2 && cyc == 100) conf = 4'd4;
        if (ph == 2 && cyc == 300) conf = 4'd5;
      end
      seen = done_flag[ph - 1];
    end
    if (!seen) check($sformatf("phase%0d_timeout", ph), int'(done_flag[ph - 1]), 1);
    elapsed = cyc - 1;
  endtask

  initial begin
    int el, ws;
    tw[0] = 1;
    for (int k = 1; k < 512; k++) tw[k] = mmul(tw[k - 1], OMEGA);

    vecs[0] = '{0, 1, 0,   0,   8, 256, 2, 1};
    vecs[1] = '{1, 3, 0,   0,   1, 511, 1, 3};
    vecs[2] = '{2, 3, 0,   0, 512,   5, 0, 3};
    vecs[3] = '{3, 3, 1,  -1,   0,  -1, 0, 3};
    vecs[4] = '{4, 2, 1,  -1,   0,  -1, 0, 3};

    // Reset held with a start command present
    rst  = 1'b0;
    conf = 4'd1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      @(negedge clk);
      check("reset_done_flag", int'(done_flag), 0);
      check("reset_write_strobes", writes_active(), 0);
    end
    conf = 4'd0;
    rst  = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_done_flag", int'(done_flag), 0);

    for (int v = 0; v < 5; v++) begin
      load(vecs[v].pat);
      if ((vecs[v].phases & 1) != 0) model_r2();
      if ((vecs[v].phases & 2) != 0) model_r4();
      push_expected();
      if ((vecs[v].phases & 1) != 0) begin
        run_phase(1, vecs[v].mid, el);
        check($sformatf("v%0d_r2_latency", v), el, 128 + PIPE);
      end
      if ((vecs[v].phases & 2) != 0) begin
        run_phase(2, vecs[v].mid, el);
        check($sformatf("v%0d_r4_latency", v), el, 4 * (128 + PIPE));
      end
      repeat (2) @(negedge clk);
      if (vecs[v].i0 >= 0) check($sformatf("v%0d_x%0d", v, vecs[v].i0), peek(vecs[v].i0), vecs[v].v0);
      if (vecs[v].i1 >= 0) check($sformatf("v%0d_x%0d", v, vecs[v].i1), peek(vecs[v].i1), vecs[v].v1);
      compare_mem($sformatf("v%0d", v));
      check($sformatf("v%0d_done_flag", v), int'(done_flag), vecs[v].done);
      conf = 4'd0;
      repeat (2) @(negedge clk);
    end

    // conf held at 1 after completion must not start another radix-2 pass
    load(4);
    model_r2();
    push_expected();
    run_phase(1, 0, el);
    check("hold_r2_latency", el, 128 + PIPE);
    ws = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      ws += writes_active();
    end
    check("hold_no_retrigger_writes", ws, 0);
    check("hold_done_flag", int'(done_flag), 3);
    compare_mem("hold");
    conf = 4'd0;
    repeat (2) @(negedge clk);

    // Reset during the stride-16 stage of the radix-4 phase, then a clean restart
    load(3);
    @(negedge clk);
    conf = 4'd2;
    repeat (132 + 40) @(negedge clk);
    rst  = 1'b0;
    conf = 4'd0;
    @(negedge clk);
    check("midreset_done_flag", int'(done_flag), 0);
    rst = 1'b1;
    ws  = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      ws += writes_active();
    end
    check("midreset_no_writes", ws, 0);
    check("midreset_idle_done", int'(done_flag), 0);
    load(4);
    model_r4();
    push_expected();
    run_phase(2, 0, el);
    check("restart_r4_latency", el, 4 * (128 + PIPE));
    repeat (2) @(negedge clk);
    compare_mem("restart");
    check("restart_done_flag", int'(done_flag), 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/top_stage.md
Name: top_stage

Overview:
- Top level of a 512-point mixed-radix number-theoretic transform (NTT) engine over q = 12289.
- Data sits in four single-word-per-cycle memory banks and is transformed in place.
- The transform is one radix-2 DIF stage (stride 256) followed by four radix-4 DIF stages (strides 64, 16, 4, 1).
- An external controller sequences the two phases through `conf` and watches `done_flag`.

Parameters:
- Q, 12289, modulus.
- DW, 14, coefficient width.
- AW, 7, bank address width (128 words per bank).
- OMEGA, 2401, primitive 512th root of unity mod Q.
- PIPE, 4, cycles from bank read address to write-back.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  synchronous, active-low reset.
- conf  input  4  command: 1 = run radix-2 phase; 2 = run radix-4 phase; 0 and 3..15 = no new command.
- done_flag  output  2  bit0 = radix-2 phase complete; bit1 = radix-4 phase complete.

Behaviour:
- Storage:
  - Four memory instances named `bank_0`..`bank_3`. Each holds a `reg [DW-1:0] bank[0:127]` array so benches can preload it hierarchically.
  - Memory is not cleared by reset.
  - Read latency is 1 cycle; write is synchronous.
- Element mapping for element i (9 bits):
  - Word address = i[8:2].
  - Bank = (i[1:0] + i[3:2] + i[5:4] + i[7:6] + 2*i[8]) mod 4.
  - This mapping makes every access below conflict-free.
- Twiddles: 512-entry ROM of OMEGA^k mod Q, built at elaboration. J = OMEGA^128 (order-4 root).
- Modular arithmetic:
  - Add/sub with conditional correction; outputs are always in [0, Q-1].
  - Multiply is the full product followed by reduction mod Q.
  - Inputs are guaranteed < Q.
- Radix-2 phase (128 issue cycles):
  - Cycle c processes j = 2c and 2c+1, each as the pair (a = x[j], b = x[j+256]).
  - a' = a+b, b' = (a-b)·OMEGA^j.
  - The four reads hit four distinct banks.
- Radix-4 phase (stages s = 64, 16, 4, 1; 128 issue cycles each):
  - Group index g = 0..127 is issued at cycle g.
  - Element indices are base + p·s, p = 0..3. Base is formed by inserting a zero digit at the stride's radix-4 position into g, and j = base mod s.
  - With t = 512/(4s):
    - y0 = x0+x1+x2+x3
    - y1 = (x0 + J·x1 − x2 − J·x3)·OMEGA^(t·j)
    - y2 = (x0 − x1 + x2 − x3)·OMEGA^(2t·j)
    - y3 = (x0 − J·x1 − x2 + J·x3)·OMEGA^(3t·j), exponents mod 512.
  - Between stages the engine waits until the pipeline drains (PIPE cycles) before issuing the next stage's reads.
- Final output: results are left in place in mixed digit-reversed order. The verification model applies the identical stage sequence.
- Control FSM states: IDLE, R2_RUN, R2_DRAIN, R4_RUN, R4_DRAIN.
  - IDLE: conf==1 starts R2_RUN and clears done_flag[0]. conf==2 starts R4_RUN (stage 64) and clears done_flag[1].
  - A command is accepted only in IDLE. conf changes during a run are ignored, and the running phase always completes.
  - R2_RUN issues 128 cycles, then R2_DRAIN for PIPE cycles, then sets done_flag[0] and returns to IDLE.
  - R4_RUN issues 128 cycles, then R4_DRAIN. After the 4th stage drains, R4_DRAIN sets done_flag[1] and returns to IDLE; otherwise it advances to the next stride.
  - A conf value held at 1 or 2 after completion does not retrigger; a new start needs conf to leave and re-enter the value.
  - done_flag bits stay high until their phase restarts or reset.
- Reset (rst==0 at a clock edge):
  - FSM goes to IDLE, done_flag = 00, all pipeline write-enables are cleared.
  - Reset during a run aborts the run; partially written bank data stays as is.

Test Plan:
- Reset: hold rst=0 for 3 cycles with conf=1 -> done_flag=00, no bank write strobes.
- Radix-2 only: x[0]=5, x[256]=3, all others 0; conf=1 -> x[0]=8, x[256]=2; done_flag=01 exactly 128+PIPE cycles after start; all other words stay 0.
- Impulse full NTT: x[0]=1, others 0; conf=1, wait for bit0, then conf=2 -> all 512 words = 1, done_flag=11.
- Constant input: all x[i]=1; full run -> x[0]=512, every other word 0.
- Random vector: conf sequence 1, 3, 2, 4, 5 with mid-run changes -> bank contents equal the software model bit-exactly; the changes have no effect.
- Reset mid radix-4 phase: rst=0 at stage 16 -> done_flag=00, FSM idle; restarting with conf=2 proceeds normally.
